// File: rtl/fetch_queue.sv
// F/D instruction queue: circular buffer of {pc, ir} pairs; one-cycle push-to-head latency, one push and one pop per cycle.
// Fetch is held off only by registered full; decode stalls never reach full combinationally.
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [31:0]              pc_F,
  input  logic [31:0]              IR_F,
  input  logic                     stall_D,
  input  logic                     flush,
  output logic                     full,
  output logic                     valid_D,
  output logic [31:0]              pc_D,
  output logic [31:0]              pc4_D,
  output logic [31:0]              IR_D,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   rp, wp, rp_next, wp_next;
  logic [AW:0]     cnt, cnt_next;
  logic            push_ok, pop;

  assign full    = (cnt == CNT_FULL);
  assign valid_D = (cnt != '0);
  assign push_ok = push & ~full & ~flush;
  assign pop     = valid_D & ~stall_D & ~flush;

  // Flush wins over everything; push while full is dropped even if a pop frees a slot.
  always_comb begin
    rp_next  = rp;
    wp_next  = wp;
    cnt_next = cnt;
    if (flush) begin
      rp_next  = '0;
      wp_next  = '0;
      cnt_next = '0;
    end else begin
      if (push_ok) wp_next = wp + PTR_ONE;
      if (pop)     rp_next = rp + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   cnt_next = cnt + CNT_ONE;
        2'b01:   cnt_next = cnt - CNT_ONE;
        default: cnt_next = cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      rp  <= rp_next;
      wp  <= wp_next;
      cnt <= cnt_next;
    end
  end

  // Storage is deliberately not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= {pc_F, IR_F};
  end

  assign head  = mem[rp];
  assign pc_D  = valid_D ? head.pc : 32'h0;
  assign IR_D  = valid_D ? head.ir : 32'h0;
  assign pc4_D = pc_D + 32'd4;
  assign count = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus queues expected PCs, a negedge monitor checks every pop in order.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic [31:0] pc_F = 32'h0;
  logic [31:0] IR_F = 32'h0;
  logic        stall_D = 1'b0;
  logic        flush = 1'b0;
  logic        full, valid_D;
  logic [31:0] pc_D, pc4_D, IR_D;
  logic [1:0]  count;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .push(push), .pc_F(pc_F), .IR_F(IR_F),
    .stall_D(stall_D), .flush(flush), .full(full), .valid_D(valid_D),
    .pc_D(pc_D), .pc4_D(pc4_D), .IR_D(IR_D), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return {16'h2508, pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [31:0] pc, input logic st, input logic fl, input logic expect_accept);
    push    = p;
    pc_F    = pc;
    IR_F    = ir_of(pc);
    stall_D = st;
    flush   = fl;
    if (expect_accept) exp_q.push_back(pc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a pop happens at the coming edge; the head must be the oldest expected entry.
  always @(negedge clk) begin
    if (reset && valid_D && !stall_D && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", pc_D, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pop_pc", pc_D, e);
        check("pop_ir", IR_D, ir_of(e));
        check("pop_pc4", pc4_D, e + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_valid", 32'(valid_D), 32'd0);
    check("rst_pc", pc_D, 32'h0);
    check("rst_pc4", pc4_D, 32'h4);
    check("rst_ir", IR_D, 32'h0);
    tick;
    reset = 1'b1;

    // Streaming, no stalls
    drive(1, 32'h3000, 0, 0, 1); tick;
    check("st_count", 32'(count), 32'd1);
    check("st_pc", pc_D, 32'h3000);
    check("st_ir", IR_D, ir_of(32'h3000));
    check("st_pc4", pc4_D, 32'h3004);
    drive(1, 32'h3004, 0, 0, 1); tick;
    check("st_count", 32'(count), 32'd1);
    check("st_pc", pc_D, 32'h3004);
    drive(1, 32'h3008, 0, 0, 1); tick;
    check("st_count", 32'(count), 32'd1);
    check("st_full", 32'(full), 32'd0);
    drive(0, 32'h0, 0, 0, 0); tick;
    check("st_drain", 32'(count), 32'd0);

    // Stall fill
    drive(1, 32'h3000, 1, 0, 1); tick;
    check("sf_count1", 32'(count), 32'd1);
    check("sf_full1", 32'(full), 32'd0);
    drive(1, 32'h3004, 1, 0, 1); tick;
    check("sf_full2", 32'(full), 32'd1);
    check("sf_count2", 32'(count), 32'd2);
    drive(1, 32'h3008, 1, 0, 0); tick;
    check("sf_hold_pc", pc_D, 32'h3000);
    check("sf_hold_cnt", 32'(count), 32'd2);
    tick;
    check("sf_hold_pc2", pc_D, 32'h3000);
    check("sf_hold_ir2", IR_D, ir_of(32'h3000));
    drive(0, 32'h0, 0, 0, 0); tick;
    check("sf_rel_count", 32'(count), 32'd1);
    check("sf_rel_full", 32'(full), 32'd0);
    check("sf_rel_pc", pc_D, 32'h3004);
    tick;
    check("sf_empty", 32'(count), 32'd0);

    // Full with simultaneous pop and push: push dropped
    drive(1, 32'h3010, 1, 0, 1); tick;
    drive(1, 32'h3014, 1, 0, 1); tick;
    check("fp_full", 32'(full), 32'd1);
    drive(1, 32'h3018, 0, 0, 0); tick;
    check("fp_count", 32'(count), 32'd1);
    check("fp_full_fall", 32'(full), 32'd0);
    check("fp_pc", pc_D, 32'h3014);
    drive(0, 32'h0, 0, 0, 0); tick;
    check("fp_empty", 32'(count), 32'd0);

    // Flush priority over push and pop
    drive(1, 32'h3020, 1, 0, 1); tick;
    drive(1, 32'h3024, 1, 0, 1); tick;
    check("fl_pre_count", 32'(count), 32'd2);
    drive(1, 32'h3010, 0, 1, 0); tick;
    exp_q.delete();
    check("fl_count", 32'(count), 32'd0);
    check("fl_valid", 32'(valid_D), 32'd0);
    check("fl_ir", IR_D, 32'h0);
    check("fl_pc4", pc4_D, 32'h4);
    drive(1, 32'h3028, 1, 0, 1); tick;
    check("fl_next_valid", 32'(valid_D), 32'd1);
    check("fl_next_pc", pc_D, 32'h3028);
    drive(0, 32'h0, 0, 0, 0); tick;
    check("fl_drain", 32'(count), 32'd0);

    // Wrap-around with intermittent one-cycle stalls
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h3000 + 32'(4 * i), 0, 0, 1); tick;
      check("wr_count", 32'(count), 32'd1);
      if (i % 3 == 2) begin
        drive(0, 32'h0, 1, 0, 0); tick;
        check("wr_stall_pc", pc_D, 32'h3000 + 32'(4 * i));
      end
    end
    drive(0, 32'h0, 0, 0, 0); tick;
    check("wr_drain", 32'(count), 32'd0);
    check("wr_all_seen", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between edges
    drive(1, 32'h3030, 1, 0, 1); tick;
    drive(1, 32'h3034, 1, 0, 1); tick;
    check("ar_pre_count", 32'(count), 32'd2);
    drive(0, 32'h0, 1, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("ar_valid", 32'(valid_D), 32'd0);
    check("ar_full", 32'(full), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_pc4", pc4_D, 32'h4);
    tick;
    reset = 1'b1;
    stall_D = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
